wrsw_txtsu_collector: RTL and testbench
=======================================

# wrsw_txtsu_collector

Collects TX timestamp reports from up to 32 endpoint ports and presents them, one at a time, on the single TXTSU handshake consumed by the fabric emulator/host side (txtsu_port_id/fid/tsval/valid/ack). Sits between the per-port endpoint timestamp outputs and the TXTSU consumer. It arbitrates port requests round-robin, buffers entries in a FIFO, and serialises them onto a valid/ack output.

## Interface
- g_num_ports, 8: number of request ports (1..32); port index is the reported port ID.
- g_fifo_depth, 16: FIFO entries (power of 2, ≥2); total capacity is g_fifo_depth+1 (FIFO plus output register).
- clk_i  in  1  fabric clock.
- rst_n_i  in  1  reset; one clock, reset is asynchronous and active-low.
- port_fid_i  in  16*g_num_ports  frame ID of port k at bits [16k+15:16k].
- port_tsval_i  in  32*g_num_ports  timestamp of port k at bits [32k+31:32k].
- port_valid_i  in  g_num_ports  level request; held with stable data until port_ack_o[k].
- port_ack_o  out  g_num_ports  one-cycle accept pulse per port.
- txtsu_port_id_o  out  5  port index of presented entry.
- txtsu_fid_o  out  16  frame ID of presented entry.
- txtsu_tsval_o  out  32  timestamp of presented entry.
- txtsu_valid_o  out  1  entry presented.
- txtsu_ack_i  in  1  consumer acknowledge.
- fifo_full_o  out  1  FIFO holds g_fifo_depth entries.

## Operation
- Reset (asynchronous): FIFO pointers/count zero, output register empty, round-robin pointer = 0. All outputs 0.
- Arbiter, evaluated each cycle from registered state:
  - Eligible port: port_valid_i[k]=1 and port_ack_o[k]=0 in this cycle (masks a port during its own ack cycle).
  - Grant only if fifo_full_o=0; count is registered, so a same-cycle FIFO pop does not free space for a grant.
  - Round-robin: search starts at (last granted index + 1) mod g_num_ports; initial start 0. At most one grant per cycle.
  - On grant of k in cycle N: {k[4:0], fid_k, tsval_k} written to FIFO at end of N; port_ack_o[k]=1 in cycle N+1 only.
- Output register with states EMPTY / PRESENT:
  - EMPTY: if FIFO non-empty, load head at end of cycle and pop; go to PRESENT.
  - PRESENT: txtsu_valid_o=1, data stable. If txtsu_ack_i=1, clear at end of cycle and go to EMPTY. txtsu_valid_o is therefore low for at least one cycle between entries.
  - txtsu_ack_i while EMPTY is ignored.
- A FIFO push and pop in the same cycle leave the count unchanged. Pointers wrap modulo g_fifo_depth.
- Requests are never dropped. When full, ports stall with valid held.

## Timing
- Min latency: port_valid_i rises in cycle N (idle block): FIFO write end of N; port_ack_o cycle N+1; txtsu_valid_o cycle N+2.
- Ack in cycle M: txtsu_valid_o low in M+1. The next buffered entry is valid in M+2.
- Port throughput: one entry per port per 2 cycles (ack-cycle masking). Aggregate throughput: one grant per cycle.
- fifo_full_o is registered and tracks count after each edge.
- Reset asserted mid-operation: all state cleared immediately and buffered entries discarded. Ports still holding valid are re-arbitrated from index 0 after release.
- port_id output is port index zero-extended to 5 bits.

## Test plan
- Single request: port 3 fid=0x1234 tsval=0xDEADBEEF rises at cycle N → port_ack_o[3] at N+1 only; txtsu_valid_o at N+2 with port_id=3, fid=0x1234, tsval=0xDEADBEEF; ack at N+4 → valid low N+5.
- Contention: ports 0, 2, 5 asserted same cycle with consumer acking each presentation after 1 cycle → output order 0, 2, 5. Then port 2 requests again with port 0 → order continues 5→0? Check: pointer after 5 grants 0 first, then 2.
- Backpressure: g_fifo_depth=4, consumer never acks, port 1 streams 8 entries → 5 acks (4 FIFO + 1 output reg), fifo_full_o=1, port 1 stalls with valid held; single ack → one more port_ack_o after 2 cycles.
- Ordering/wrap: 40 entries from port 7 with fid 0..39, random ack delays 0-5 cycles → fids 0..39 delivered in order, no duplicates or losses.
- Spurious ack: txtsu_ack_i pulses while txtsu_valid_o=0 → no state change; a subsequent entry is still presented and needs its own ack.
- Reset mid-op: 3 entries buffered, rst_n_i low asynchronously between edges → all outputs 0 immediately. After release, still-held port 4 request is delivered once as a fresh entry.

Source files
------------

// File: rtl/wrsw_txtsu_collector_if.sv
// TXTSU output handshake bundle.
// master: the collector (drives port_id/fid/tsval/valid, receives ack).
// slave:  the consumer (observes the entry, drives ack).
interface wrsw_txtsu_collector_if;
  logic [4:0]  port_id;
  logic [15:0] fid;
  logic [31:0] tsval;
  logic        valid;
  logic        ack;

  modport master (output port_id, fid, tsval, valid, input ack);
  modport slave  (input port_id, fid, tsval, valid, output ack);
endinterface

// File: rtl/wrsw_txtsu_collector.sv
// TX timestamp collector: round-robin arbitration of up to 32 endpoint timestamp
// requests into a FIFO, followed by a one-entry output register serialised on
// the TXTSU valid/ack handshake.
// Ports:
//   clk_i, rst_n_i        clock, asynchronous active-low reset
//   port_fid_i            16-bit frame ID per port, port k at [16k+15:16k]
//   port_tsval_i          32-bit timestamp per port, port k at [32k+31:32k]
//   port_valid_i          level request per port, held until port_ack_o[k]
//   port_ack_o            one-cycle accept pulse per port
//   txtsu                 output handshake (master modport)
//   fifo_full_o           FIFO holds g_fifo_depth entries
module wrsw_txtsu_collector #(
  parameter int unsigned g_num_ports  = 8,
  parameter int unsigned g_fifo_depth = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic [16*g_num_ports-1:0]  port_fid_i,
  input  logic [32*g_num_ports-1:0]  port_tsval_i,
  input  logic [g_num_ports-1:0]     port_valid_i,
  output logic [g_num_ports-1:0]     port_ack_o,
  wrsw_txtsu_collector_if.master     txtsu,
  output logic                       fifo_full_o
);

  localparam int unsigned PtrW = $clog2(g_fifo_depth);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [0:0] {StEmpty, StPresent} out_state_e;

  // Entry layout: {port_id[4:0], fid[15:0], tsval[31:0]}
  logic [52:0]            mem_q [g_fifo_depth];
  logic [PtrW-1:0]        wr_q, wr_d, rd_q, rd_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [g_num_ports-1:0] ack_q, ack_d;
  logic [4:0]             rr_q, rr_d;
  logic                   grant;
  logic [4:0]             grant_idx;
  logic [52:0]            grant_entry;
  logic [5:0]             cand, rr_next;
  logic [63:0]            elig_pad;
  logic                   pop, fifo_empty;
  out_state_e             state_q, state_d;
  logic [52:0]            out_q, out_d;

  assign fifo_full_o = (cnt_q == CntW'(g_fifo_depth));
  assign fifo_empty  = (cnt_q == '0);
  assign port_ack_o  = ack_q;

  // Arbiter works purely from registered state: ack_q masks a port during its
  // own ack cycle and the registered count blocks grants while full.
  always_comb begin
    elig_pad  = 64'(port_valid_i & ~ack_q);
    grant     = 1'b0;
    grant_idx = '0;
    cand      = '0;
    if (!fifo_full_o) begin
      for (int unsigned i = 0; i < g_num_ports; i++) begin
        cand = 6'(rr_q) + 6'(i);
        if (cand >= 6'(g_num_ports)) cand = cand - 6'(g_num_ports);
        if (!grant && elig_pad[cand]) begin
          grant     = 1'b1;
          grant_idx = cand[4:0];
        end
      end
    end
  end

  always_comb begin
    ack_d       = '0;
    grant_entry = '0;
    for (int unsigned k = 0; k < g_num_ports; k++) begin
      if (grant && (5'(k) == grant_idx)) begin
        ack_d[k]    = 1'b1;
        grant_entry = {grant_idx, port_fid_i[16*k +: 16], port_tsval_i[32*k +: 32]};
      end
    end
    rr_d    = rr_q;
    rr_next = {1'b0, grant_idx} + 6'd1;
    if (rr_next == 6'(g_num_ports)) rr_next = '0;
    if (grant) rr_d = rr_next[4:0];
  end

  // FIFO bookkeeping; a simultaneous push and pop leaves the count unchanged.
  always_comb begin
    wr_d  = grant ? wr_q + PtrW'(1) : wr_q;
    rd_d  = pop ? rd_q + PtrW'(1) : rd_q;
    cnt_d = cnt_q + CntW'(grant) - CntW'(pop);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ack_q <= '0;
      rr_q  <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      ack_q <= ack_d;
      rr_q  <= rr_d;
    end
  end

  // Storage needs no reset: the count gates every read.
  always_ff @(posedge clk_i) begin
    if (grant) mem_q[wr_q] <= grant_entry;
  end

  // Output register FSM: state register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= StEmpty;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  // Output register FSM: next state. Ack while empty is ignored.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    unique case (state_q)
      StEmpty: begin
        if (!fifo_empty) begin
          state_d = StPresent;
          out_d   = mem_q[rd_q];
        end
      end
      StPresent: begin
        if (txtsu.ack) begin
          state_d = StEmpty;
          out_d   = '0;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  // Output register FSM: outputs.
  always_comb begin
    pop           = (state_q == StEmpty) && !fifo_empty;
    txtsu.valid   = (state_q == StPresent);
    txtsu.port_id = out_q[52:48];
    txtsu.fid     = out_q[47:32];
    txtsu.tsval   = out_q[31:0];
  end

endmodule

// File: tb/tb_wrsw_txtsu_collector.sv
// Directed self-checking bench for wrsw_txtsu_collector (8 ports, FIFO depth 4).
module tb_wrsw_txtsu_collector;
  localparam int unsigned NumPorts = 8;
  localparam int unsigned Depth    = 4;

  logic                    clk_i = 1'b0;
  logic                    rst_n_i;
  logic [16*NumPorts-1:0]  port_fid_i;
  logic [32*NumPorts-1:0]  port_tsval_i;
  logic [NumPorts-1:0]     port_valid_i;
  logic [NumPorts-1:0]     port_ack_o;
  logic                    fifo_full_o;

  wrsw_txtsu_collector_if txtsu_if ();

  wrsw_txtsu_collector #(
    .g_num_ports (NumPorts),
    .g_fifo_depth(Depth)
  ) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .port_fid_i  (port_fid_i),
    .port_tsval_i(port_tsval_i),
    .port_valid_i(port_valid_i),
    .port_ack_o  (port_ack_o),
    .txtsu       (txtsu_if),
    .fifo_full_o (fifo_full_o)
  );

  always #5 clk_i = ~clk_i;

  int          n_cmp = 0;
  int          n_err = 0;
  int          src_left  [NumPorts];
  logic [15:0] src_fid   [NumPorts];
  int          acks_seen [NumPorts];
  bit          auto_ack;
  bit          rand_delay;
  int          ack_delay;
  int          wait_cnt;
  logic [52:0] got_q [$];
  logic [52:0] e;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ts_of(input int k, input logic [15:0] fid);
    return {8'(k), 8'h5A, fid};
  endfunction

  task automatic drive_port(input int k);
    port_fid_i[16*k +: 16]   = src_fid[k];
    port_tsval_i[32*k +: 32] = ts_of(k, src_fid[k]);
    port_valid_i[k]          = 1'b1;
  endtask

  task automatic start_src(input int k, input logic [15:0] fid, input int n);
    src_left[k] = n;
    src_fid[k]  = fid;
    drive_port(k);
  endtask

  // Advance one cycle; inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
    for (int k = 0; k < NumPorts; k++) begin
      if (port_ack_o[k]) begin
        acks_seen[k]++;
        if (src_left[k] > 0) src_left[k]--;
        if (src_left[k] > 0) begin
          src_fid[k] = src_fid[k] + 16'd1;
          drive_port(k);
        end else begin
          port_valid_i[k] = 1'b0;
        end
      end
    end
    if (auto_ack) begin
      txtsu_if.ack = 1'b0;
      if (txtsu_if.valid) begin
        if (wait_cnt >= ack_delay) begin
          txtsu_if.ack = 1'b1;
          got_q.push_back({txtsu_if.port_id, txtsu_if.fid, txtsu_if.tsval});
          wait_cnt = 0;
          if (rand_delay) ack_delay = int'($urandom_range(0, 5));
        end else begin
          wait_cnt++;
        end
      end
    end
  endtask

  task automatic wait_q(input int n, input int budget);
    int c = 0;
    while (got_q.size() < n && c < budget) begin
      tick();
      c++;
    end
    check_eq("wait_entries", 64'(got_q.size()), 64'(n));
  endtask

  task automatic do_reset();
    rst_n_i      = 1'b0;
    port_valid_i = '0;
    port_fid_i   = '0;
    port_tsval_i = '0;
    txtsu_if.ack = 1'b0;
    auto_ack     = 1'b0;
    rand_delay   = 1'b0;
    ack_delay    = 0;
    wait_cnt     = 0;
    got_q.delete();
    for (int k = 0; k < NumPorts; k++) begin
      src_left[k]  = 0;
      src_fid[k]   = '0;
      acks_seen[k] = 0;
    end
    tick();
    tick();
    rst_n_i = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    do_reset();
    check_eq("rst_valid", 64'(txtsu_if.valid), 64'd0);
    check_eq("rst_port_ack", 64'(port_ack_o), 64'd0);
    check_eq("rst_full", 64'(fifo_full_o), 64'd0);
    check_eq("rst_data", {11'd0, txtsu_if.port_id, txtsu_if.fid, txtsu_if.tsval}, 64'd0);

    // Single request with minimum latency.
    start_src(3, 16'h1234, 1);
    port_tsval_i[32*3 +: 32] = 32'hDEADBEEF;
    check_eq("single_N_ack", 64'(port_ack_o), 64'd0);
    tick();
    check_eq("single_N1_ack", 64'(port_ack_o), 64'h08);
    check_eq("single_N1_valid", 64'(txtsu_if.valid), 64'd0);
    tick();
    check_eq("single_N2_ack", 64'(port_ack_o), 64'd0);
    check_eq("single_N2_valid", 64'(txtsu_if.valid), 64'd1);
    check_eq("single_N2_data", {11'd0, txtsu_if.port_id, txtsu_if.fid, txtsu_if.tsval},
             {11'd0, 5'd3, 16'h1234, 32'hDEADBEEF});
    tick();
    check_eq("single_N3_valid", 64'(txtsu_if.valid), 64'd1);
    tick();
    txtsu_if.ack = 1'b1;
    check_eq("single_N4_valid", 64'(txtsu_if.valid), 64'd1);
    tick();
    txtsu_if.ack = 1'b0;
    check_eq("single_N5_valid", 64'(txtsu_if.valid), 64'd0);
    check_eq("single_full", 64'(fifo_full_o), 64'd0);

    // Contention: round-robin from a fresh pointer, then from after port 5.
    do_reset();
    auto_ack  = 1'b1;
    ack_delay = 1;
    start_src(0, 16'h0100, 1);
    start_src(2, 16'h0200, 1);
    start_src(5, 16'h0500, 1);
    wait_q(3, 40);
    if (got_q.size() >= 3) begin
      check_eq("rr_first", 64'(got_q[0][52:32]), {43'd0, 5'd0, 16'h0100});
      check_eq("rr_second", 64'(got_q[1][52:32]), {43'd0, 5'd2, 16'h0200});
      check_eq("rr_third", 64'(got_q[2][52:32]), {43'd0, 5'd5, 16'h0500});
    end
    start_src(2, 16'h0210, 1);
    start_src(0, 16'h0010, 1);
    wait_q(5, 40);
    if (got_q.size() >= 5) begin
      check_eq("rr_fourth", 64'(got_q[3][52:32]), {43'd0, 5'd0, 16'h0010});
      check_eq("rr_fifth", 64'(got_q[4][52:32]), {43'd0, 5'd2, 16'h0210});
    end

    // Backpressure: consumer idle, port 1 streams 8 entries.
    do_reset();
    start_src(1, 16'h0000, 8);
    repeat (20) tick();
    check_eq("bp_acks", 64'(acks_seen[1]), 64'd5);
    check_eq("bp_full", 64'(fifo_full_o), 64'd1);
    check_eq("bp_stall_ack", 64'(port_ack_o), 64'd0);
    check_eq("bp_head", {31'd0, txtsu_if.valid, 16'd0, txtsu_if.fid}, {31'd0, 1'b1, 32'h0});
    txtsu_if.ack = 1'b1;
    tick();
    txtsu_if.ack = 1'b0;
    check_eq("bp_M1_valid", 64'(txtsu_if.valid), 64'd0);
    check_eq("bp_M1_full", 64'(fifo_full_o), 64'd1);
    tick();
    check_eq("bp_M2_valid", 64'(txtsu_if.valid), 64'd1);
    check_eq("bp_M2_fid", 64'(txtsu_if.fid), 64'd1);
    check_eq("bp_M2_full", 64'(fifo_full_o), 64'd0);
    check_eq("bp_M2_ack", 64'(port_ack_o), 64'd0);
    tick();
    check_eq("bp_M3_ack", 64'(port_ack_o), 64'h02);
    check_eq("bp_M3_full", 64'(fifo_full_o), 64'd1);
    repeat (5) tick();
    check_eq("bp_acks_after", 64'(acks_seen[1]), 64'd6);

    // Ordering through pointer wrap with random consumer delays.
    do_reset();
    auto_ack   = 1'b1;
    rand_delay = 1'b1;
    ack_delay  = int'($urandom_range(0, 5));
    start_src(7, 16'h0000, 40);
    wait_q(40, 2000);
    repeat (10) tick();
    check_eq("order_total", 64'(got_q.size()), 64'd40);
    check_eq("order_port_acks", 64'(acks_seen[7]), 64'd40);
    for (int i = 0; i < 40 && i < got_q.size(); i++) begin
      e = got_q[i];
      check_eq($sformatf("order_%0d", i), {11'd0, e}, {11'd0, 5'd7, 16'(i), ts_of(7, 16'(i))});
    end

    // Spurious ack while nothing is presented, including the load cycle.
    do_reset();
    txtsu_if.ack = 1'b1;
    tick();
    tick();
    check_eq("spur_valid", 64'(txtsu_if.valid), 64'd0);
    check_eq("spur_full", 64'(fifo_full_o), 64'd0);
    start_src(6, 16'h0600, 1);
    tick();
    tick();
    txtsu_if.ack = 1'b0;
    check_eq("spur_present", {31'd0, txtsu_if.valid, 11'd0, txtsu_if.port_id, txtsu_if.fid},
             {31'd0, 1'b1, 11'd0, 5'd6, 16'h0600});
    repeat (3) tick();
    check_eq("spur_held", 64'(txtsu_if.valid), 64'd1);
    txtsu_if.ack = 1'b1;
    tick();
    txtsu_if.ack = 1'b0;
    check_eq("spur_cleared", 64'(txtsu_if.valid), 64'd0);

    // Asynchronous reset with entries buffered and port 4 requesting.
    do_reset();
    start_src(1, 16'h0011, 1);
    start_src(2, 16'h0022, 1);
    start_src(3, 16'h0033, 1);
    repeat (5) tick();
    check_eq("mid_buffered", 64'(acks_seen[1] + acks_seen[2] + acks_seen[3]), 64'd3);
    check_eq("mid_valid_pre", 64'(txtsu_if.valid), 64'd1);
    start_src(4, 16'h0440, 1);
    #2;
    rst_n_i = 1'b0;
    #1;
    check_eq("mid_rst_valid", 64'(txtsu_if.valid), 64'd0);
    check_eq("mid_rst_ack", 64'(port_ack_o), 64'd0);
    check_eq("mid_rst_full", 64'(fifo_full_o), 64'd0);
    check_eq("mid_rst_data", {11'd0, txtsu_if.port_id, txtsu_if.fid, txtsu_if.tsval}, 64'd0);
    tick();
    rst_n_i   = 1'b1;
    got_q.delete();
    auto_ack  = 1'b1;
    ack_delay = 0;
    wait_cnt  = 0;
    wait_q(1, 30);
    repeat (10) tick();
    check_eq("mid_after_count", 64'(got_q.size()), 64'd1);
    if (got_q.size() >= 1) begin
      e = got_q[0];
      check_eq("mid_after_entry", {11'd0, e}, {11'd0, 5'd4, 16'h0440, ts_of(4, 16'h0440)});
    end
    check_eq("mid_port4_acks", 64'(acks_seen[4]), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
